lcd_frame_scanner: RTL and testbench
====================================

LCD_FRAME_SCANNER -- requirements
Module: lcd_frame_scanner

Interface
REQ-001 Parameter H_RES, default 320, pixels per line.
REQ-002 Parameter V_RES, default 240, lines per frame.
REQ-003 Parameter FG_COLOR, default 16'hFFFF, RGB565 word sent when the sprite pixel is set.
REQ-004 Parameter BG_COLOR, default 16'h0000, RGB565 word sent when the sprite pixel is clear.
REQ-005 Parameter MEMWR_CMD, default 8'h2C, LCD memory-write command byte sent before each frame.
REQ-006 Port clk, input, 1, the single clock; every flop is on posedge clk.
REQ-007 Port reset, input, 1, synchronous active-high reset.
REQ-008 Port frameStart, input, 1, request to render one frame; sampled only in IDLE.
REQ-009 Port checkX, output, 9, column currently queried from the sprite.
REQ-010 Port checkY, output, 8, row currently queried from the sprite.
REQ-011 Port isSet, input, 1, combinational sprite answer for (checkX, checkY), valid in the same cycle.
REQ-012 Port outData, output, 16, word to the LCD bus driver.
REQ-013 Port outIsCmd, output, 1, marks outData as a command (1) or pixel data (0).
REQ-014 Port outValid, output, 1, outData and outIsCmd are valid.
REQ-015 Port outReady, input, 1, downstream accepts the word when outValid and outReady are both high.
REQ-016 Port busy, output, 1, high in every state except IDLE.
REQ-017 Port physicsTick, output, 1, one-cycle pulse per completed frame; drives the sprite physics update.

Function
REQ-018 The FSM SHALL have the states IDLE, CMD, PIXELS and DONE.
REQ-019 In IDLE, frameStart=1 SHALL move the FSM to CMD on the next edge, with the counters at x=0, y=0.
REQ-020 In CMD, outValid=1, outIsCmd=1 and outData={8'h00,MEMWR_CMD}; the FSM moves to PIXELS on handshake.
REQ-021 In PIXELS, checkX and checkY SHALL equal the x and y counters, and isSet SHALL be sampled in the same cycle.
REQ-022 The output SHALL be a one-entry register; a pixel loads when the register is empty or being drained in that cycle.
REQ-023 A loaded pixel word SHALL be FG_COLOR if isSet=1, else BG_COLOR, with outIsCmd=0.
REQ-024 Latency from a counter position to its word on outData SHALL be exactly 1 cycle when outReady is held high.
REQ-025 With outReady held high, the block SHALL sustain one pixel per cycle.
REQ-026 When outReady=0 and outValid=1, outData, outIsCmd, checkX, checkY and the counters SHALL hold.
REQ-027 Counter wrap: x increments per loaded pixel; x=H_RES-1 wraps to 0 and increments y.
REQ-028 After the pixel (H_RES-1, V_RES-1) is loaded, no further pixel SHALL load, and the FSM SHALL enter DONE once that word is accepted.
REQ-029 DONE SHALL assert physicsTick for exactly one cycle and return to IDLE on the next edge.
REQ-030 Every frame SHALL contain exactly 1 command word followed by H_RES*V_RES pixel words.
REQ-031 frameStart asserted outside IDLE SHALL be ignored and not queued.
REQ-032 frameStart asserted in the same cycle as the DONE pulse SHALL be ignored; frameStart held high in IDLE starts back-to-back frames.
REQ-033 outValid SHALL not deassert before its handshake, and outData SHALL not change while outValid=1 and outReady=0.

Reset
REQ-034 reset=1 SHALL force IDLE, x=y=0, and outValid, busy and physicsTick to 0.
REQ-035 On reset, outData SHALL be 16'h0000, outIsCmd 0, and checkX/checkY 0.
REQ-036 A reset mid-frame SHALL abort the frame in the same edge, without a physicsTick pulse and without further words.
REQ-037 reset SHALL take priority over frameStart and over any handshake in the same cycle.

Structure
REQ-038 A shared package SHALL hold the state enum, LCD_W=320, LCD_H=240, the RGB565 color type and the MEMWR_CMD constant.
REQ-039 The x/y raster counter SHALL be a sub-module raster_counter (advance enable, wrap flags, last-pixel flag).
REQ-040 Counter widths SHALL be $clog2 of H_RES and V_RES, zero-extended onto checkX/checkY.

Verification
REQ-041 Full frame, outReady=1, isSet tied 0 -> 1 command word 0x002C, then 76800 words of 0x0000, then one physicsTick pulse.
REQ-042 isSet driven by a model of a circle at (240,200) with squared radius 32 -> FG_COLOR exactly where the model is set, in raster order.
REQ-043 Random outReady with a 30% stall rate -> no word lost or duplicated, outData stable during stalls, 76801 words total.
REQ-044 Reset pulsed at pixel 1000 -> outValid=0 on the next cycle, FSM in IDLE, no physicsTick pulse.
REQ-045 frameStart pulsed during PIXELS, then held high through two frames -> no extra frame mid-frame, back-to-back frames, exactly 2 physicsTick pulses.
REQ-046 H_RES=4, V_RES=3 -> wrap at x=3 checked, the word after 12 pixel words absent, DONE one cycle after the last handshake.

Source files
------------

// File: rtl/lcd_frame_scanner_pkg.sv
// Shared types and constants for the LCD frame scanner.
// Panel geometry, RGB565 word type, FSM states.
package lcd_frame_scanner_pkg;

  localparam int LCD_W = 320;
  localparam int LCD_H = 240;

  localparam logic [7:0] LCD_MEMWR_CMD = 8'h2C;

  typedef logic [15:0] rgb565_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMD,
    S_PIXELS,
    S_DONE
  } state_e;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lcd_frame_scanner_if.sv
// Word stream from the scanner to the LCD bus driver.
// valid/ready handshake; outIsCmd tags command words.
interface lcd_frame_scanner_if;
  import lcd_frame_scanner_pkg::*;

  rgb565_t outData;
  logic    outIsCmd;
  logic    outValid;
  logic    outReady;

  modport master (
    output outData,
    output outIsCmd,
    output outValid,
    input  outReady
  );

  modport slave (
    input  outData,
    input  outIsCmd,
    input  outValid,
    output outReady
  );

endinterface

// File: rtl/lcd_frame_scanner_raster_counter.sv
// Raster x/y counter: x runs along a line, y steps per wrap.
// Flags end of line, end of frame column and the final pixel.
module raster_counter
  import lcd_frame_scanner_pkg::*;
#(
  parameter int H_RES = LCD_W,
  parameter int V_RES = LCD_H,
  parameter int XW    = cnt_w(H_RES),
  parameter int YW    = cnt_w(V_RES)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_i,
  input  logic          adv_i,
  output logic [XW-1:0] x_o,
  output logic [YW-1:0] y_o,
  output logic          x_wrap_o,
  output logic          y_wrap_o,
  output logic          last_o
);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;

  assign x_wrap_o = (x_q == XW'(H_RES - 1));
  assign y_wrap_o = (y_q == YW'(V_RES - 1));
  assign last_o   = x_wrap_o & y_wrap_o;
  assign x_o      = x_q;
  assign y_o      = y_q;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clr_i) begin
      x_d = '0;
      y_d = '0;
    end else if (adv_i) begin
      if (x_wrap_o) begin
        x_d = '0;
        y_d = y_wrap_o ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

endmodule

// File: rtl/lcd_frame_scanner.sv
// Streams one LCD frame: memory-write command, then every
// pixel in raster order coloured by the sprite lookup.
module lcd_frame_scanner
  import lcd_frame_scanner_pkg::*;
#(
  parameter int         H_RES     = LCD_W,
  parameter int         V_RES     = LCD_H,
  parameter rgb565_t    FG_COLOR  = 16'hFFFF,
  parameter rgb565_t    BG_COLOR  = 16'h0000,
  parameter logic [7:0] MEMWR_CMD = LCD_MEMWR_CMD
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                frameStart,
  output logic [8:0]          checkX,
  output logic [7:0]          checkY,
  input  logic                isSet,
  output logic                busy,
  output logic                physicsTick,
  lcd_frame_scanner_if.master lcd
);

  localparam int XW = cnt_w(H_RES);
  localparam int YW = cnt_w(V_RES);

  state_e  state_q, state_d;
  rgb565_t data_q, data_d;
  logic    cmd_q, cmd_d;
  logic    valid_q, valid_d;
  logic    last_q, last_d;
  logic    clr, load, drain;

  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          x_wrap, y_wrap, last_pix;
  logic          unused_wrap;

  raster_counter #(
    .H_RES(H_RES),
    .V_RES(V_RES),
    .XW   (XW),
    .YW   (YW)
  ) u_raster (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (clr),
    .adv_i   (load),
    .x_o     (x),
    .y_o     (y),
    .x_wrap_o(x_wrap),
    .y_wrap_o(y_wrap),
    .last_o  (last_pix)
  );

  // only the combined last-pixel flag steers the FSM
  assign unused_wrap = x_wrap ^ y_wrap;

  assign drain = valid_q & lcd.outReady;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cmd_d   = cmd_q;
    valid_d = valid_q;
    last_d  = last_q;
    clr     = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (frameStart) begin
          state_d = S_CMD;
          clr     = 1'b1;
          valid_d = 1'b1;
          cmd_d   = 1'b1;
          data_d  = {8'h00, MEMWR_CMD};
          last_d  = 1'b0;
        end
      end
      S_CMD: begin
        if (drain) begin
          state_d = S_PIXELS;
          valid_d = 1'b0;
        end
      end
      S_PIXELS: begin
        if (drain) valid_d = 1'b0;
        if (!last_q && (!valid_q || lcd.outReady)) begin
          load    = 1'b1;
          valid_d = 1'b1;
          cmd_d   = 1'b0;
          data_d  = isSet ? FG_COLOR : BG_COLOR;
          last_d  = last_pix;
        end else if (last_q && drain) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      cmd_q   <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cmd_q   <= cmd_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign lcd.outData  = data_q;
  assign lcd.outIsCmd = cmd_q;
  assign lcd.outValid = valid_q;

  assign checkX      = 9'(x);
  assign checkY      = 8'(y);
  assign busy        = (state_q != S_IDLE);
  assign physicsTick = (state_q == S_DONE);

endmodule

// File: tb/tb_lcd_frame_scanner.sv
// Scoreboard bench: full-size circle frame plus a 4x3 instance
// for stalls, wrap, back-to-back and ignored frameStart.
module tb_lcd_frame_scanner;
  import lcd_frame_scanner_pkg::*;

  localparam int SH = 4;
  localparam int SV = 3;
  localparam int SN = SH * SV;
  localparam int BN = LCD_W * LCD_H;
  localparam logic [15:0] SFG  = 16'hF800;
  localparam logic [15:0] SBG  = 16'h001F;
  localparam logic [7:0]  SCMD = 8'hA5;

  typedef struct packed {
    logic        cmd;
    logic [15:0] data;
  } word_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic rst_b, rst_s, fs_b, fs_s;
  logic busy_b, busy_s, tick_b, tick_s, set_b, set_s;
  logic [8:0] cx_b, cx_s;
  logic [7:0] cy_b, cy_s;
  logic [SN-1:0] pat_s;
  logic stall_on = 1'b0;
  word_t exp_b[$];
  word_t exp_s[$];

  lcd_frame_scanner_if bus_b ();
  lcd_frame_scanner_if bus_s ();

  lcd_frame_scanner dut_b (
    .clk(clk), .reset(rst_b), .frameStart(fs_b),
    .checkX(cx_b), .checkY(cy_b), .isSet(set_b),
    .busy(busy_b), .physicsTick(tick_b), .lcd(bus_b)
  );

  lcd_frame_scanner #(
    .H_RES(SH), .V_RES(SV), .FG_COLOR(SFG),
    .BG_COLOR(SBG), .MEMWR_CMD(SCMD)
  ) dut_s (
    .clk(clk), .reset(rst_s), .frameStart(fs_s),
    .checkX(cx_s), .checkY(cy_s), .isSet(set_s),
    .busy(busy_s), .physicsTick(tick_s), .lcd(bus_s)
  );

  function automatic logic circ(input int x, input int y);
    return ((x - 240) * (x - 240) + (y - 200) * (y - 200)) <= 32;
  endfunction

  function automatic logic [15:0] scol(input int i);
    return pat_s[i] ? SFG : SBG;
  endfunction

  assign set_b = circ(int'(cx_b), int'(cy_b));
  assign set_s = pat_s[4'(int'(cy_s) * SH + int'(cx_s))];

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic push_b();
    exp_b.push_back({1'b1, 16'h002C});
    for (int y = 0; y < LCD_H; y++)
      for (int x = 0; x < LCD_W; x++)
        exp_b.push_back({1'b0, circ(x, y) ? 16'hFFFF : 16'h0000});
  endtask

  task automatic push_s();
    exp_s.push_back({1'b1, 8'h00, SCMD});
    for (int i = 0; i < SN; i++)
      exp_s.push_back({1'b0, scol(i)});
  endtask

  // ---------------- monitors ----------------
  logic  pv_b = 1'b0, pr_b = 1'b0, pt_b = 1'b0;
  word_t pw_b;
  int words_b = 0, ticks_b = 0;
  int tick_cyc_b = 0, cmd_cyc_b = 0, hs_cyc_b = 0;

  always @(negedge clk) begin
    word_t w, e;
    w = {bus_b.outIsCmd, bus_b.outData};
    if (rst_b) begin
      pv_b = 1'b0;
      pt_b = 1'b0;
    end else begin
      if (pv_b && !pr_b) begin
        chk("b_stall_valid", 32'(bus_b.outValid), 1);
        chk("b_stall_word", 32'(w), 32'(pw_b));
      end
      if (bus_b.outValid && bus_b.outReady) begin
        if (exp_b.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL b_extra_word: got %h expected none", w);
        end else begin
          e = exp_b.pop_front();
          chk("b_word", 32'(w), 32'(e));
        end
        words_b++;
        hs_cyc_b = cyc;
        if (w.cmd) cmd_cyc_b = cyc;
      end
      if (tick_b) begin
        chk("b_tick_width", 32'(pt_b), 0);
        ticks_b++;
        tick_cyc_b = cyc;
      end
      pv_b = bus_b.outValid;
      pr_b = bus_b.outReady;
      pw_b = w;
      pt_b = tick_b;
    end
  end

  logic  pv_s = 1'b0, pr_s = 1'b0, pt_s = 1'b0;
  word_t pw_s;
  int words_s = 0, ticks_s = 0, cmds_s = 0;
  int tick_cyc_s = 0, cmd_cyc_s = 0, hs_cyc_s = 0;

  always @(negedge clk) begin
    word_t w, e;
    w = {bus_s.outIsCmd, bus_s.outData};
    if (rst_s) begin
      pv_s = 1'b0;
      pt_s = 1'b0;
    end else begin
      if (pv_s && !pr_s) begin
        chk("s_stall_valid", 32'(bus_s.outValid), 1);
        chk("s_stall_word", 32'(w), 32'(pw_s));
      end
      if (bus_s.outValid && bus_s.outReady) begin
        if (exp_s.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL s_extra_word: got %h expected none", w);
        end else begin
          e = exp_s.pop_front();
          chk("s_word", 32'(w), 32'(e));
        end
        words_s++;
        hs_cyc_s = cyc;
        if (w.cmd) begin
          cmds_s++;
          cmd_cyc_s = cyc;
        end
      end
      if (tick_s) begin
        chk("s_tick_width", 32'(pt_s), 0);
        chk("s_done_after_hs", tick_cyc_s == 0 ? cyc - hs_cyc_s : cyc - hs_cyc_s, 1);
        ticks_s++;
        tick_cyc_s = cyc;
      end
      pv_s = bus_s.outValid;
      pr_s = bus_s.outReady;
      pw_s = w;
      pt_s = tick_s;
    end
  end

  // ---------------- stimulus ----------------
  function automatic int cnt(input int sel);
    case (sel)
      0:       return ticks_b;
      1:       return words_b;
      2:       return ticks_s;
      3:       return words_s;
      default: return cmds_s;
    endcase
  endfunction

  task automatic wait_cnt(input int sel, input int target,
                          input int lim, input string n);
    int k;
    k = 0;
    while (cnt(sel) < target && k < lim) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk(n, cnt(sel), target);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int b0, t0, w0;
    rst_b = 1'b1;
    rst_s = 1'b1;
    fs_b  = 1'b1;
    fs_s  = 1'b1;
    pat_s = '0;
    bus_b.outReady = 1'b1;
    bus_s.outReady = 1'b1;
    repeat (3) step();
    @(negedge clk);
    chk("rst_busy", busy_b, 0);
    chk("rst_valid", bus_b.outValid, 0);
    chk("rst_tick", tick_b, 0);
    chk("rst_data", bus_b.outData, 0);
    chk("rst_is_cmd", bus_b.outIsCmd, 0);
    chk("rst_check_xy", {cx_b, cy_b}, 0);
    chk("rst_busy_s", busy_s, 0);
    step();
    rst_b = 1'b0;
    rst_s = 1'b0;
    fs_b  = 1'b0;
    fs_s  = 1'b0;

    // full-size frame, circle sprite, ready held high
    push_b();
    step(); fs_b = 1'b1;
    step(); fs_b = 1'b0;
    wait_cnt(0, 1, BN + 100, "b_frame_tick");
    chk("b_throughput", tick_cyc_b - cmd_cyc_b, BN + 2);
    chk("b_done_latency", tick_cyc_b - hs_cyc_b, 1);
    chk("b_frame_words", words_b, BN + 1);
    chk("b_queue_drained", exp_b.size(), 0);
    @(negedge clk);
    chk("b_idle_after_done", busy_b, 0);
    chk("b_tick_cleared", tick_b, 0);

    // reset at pixel 1000 aborts the frame
    w0 = words_b;
    t0 = ticks_b;
    push_b();
    step(); fs_b = 1'b1;
    step(); fs_b = 1'b0;
    wait_cnt(1, w0 + 1001, 1200, "b_reach_px1000");
    step(); rst_b = 1'b1;
    exp_b.delete();
    step(); rst_b = 1'b0;
    @(negedge clk);
    chk("b_abort_valid", bus_b.outValid, 0);
    chk("b_abort_busy", busy_b, 0);
    repeat (20) @(negedge clk);
    chk("b_abort_no_tick", ticks_b, t0);
    chk("b_abort_no_words", words_b, w0 + 1001);

    // small frame: raster order, wrap and 1-cycle latency
    pat_s = 12'($urandom());
    push_s();
    step(); fs_s = 1'b1;
    step(); fs_s = 1'b0;
    @(negedge clk);
    chk("s_cmd_word", {bus_s.outValid, bus_s.outIsCmd, bus_s.outData},
        {2'b11, 8'h00, SCMD});
    for (int j = 1; j <= SN + 2; j++) begin
      @(negedge clk);
      if (j <= SN) begin
        chk("s_check_x", cx_s, (j - 1) % SH);
        chk("s_check_y", cy_s, (j - 1) / SH);
      end
      if (j >= 2 && j <= SN + 1)
        chk("s_latency_word", {bus_s.outValid, bus_s.outData},
            {1'b1, scol(j - 2)});
      if (j == SN + 2) begin
        chk("s_no_13th_word", bus_s.outValid, 0);
        chk("s_done_tick", tick_s, 1);
      end
    end
    step();

    // random 30% back-pressure
    stall_on = 1'b1;
    fork
      while (stall_on) begin
        step();
        bus_s.outReady = ($urandom_range(99) >= 30);
      end
      begin
        for (int f = 0; f < 3; f++) begin
          w0 = words_s;
          t0 = ticks_s;
          pat_s = 12'($urandom());
          push_s();
          step(); fs_s = 1'b1;
          step(); fs_s = 1'b0;
          wait_cnt(2, t0 + 1, 200, "s_stall_tick");
          chk("s_stall_words", words_s - w0, SN + 1);
          step();
        end
        stall_on = 1'b0;
      end
    join
    step();
    bus_s.outReady = 1'b1;
    repeat (3) step();

    // frameStart during PIXELS is ignored
    w0 = words_s;
    t0 = ticks_s;
    pat_s = 12'($urandom());
    push_s();
    step(); fs_s = 1'b1;
    step(); fs_s = 1'b0;
    wait_cnt(3, w0 + 4, 50, "s_mid_reach");
    step(); fs_s = 1'b1;
    step(); fs_s = 1'b0;
    wait_cnt(2, t0 + 1, 50, "s_mid_tick");
    repeat (10) @(negedge clk);
    chk("s_mid_ignored_busy", busy_s, 0);
    chk("s_mid_words", words_s - w0, SN + 1);

    // frameStart held: two back-to-back frames
    w0 = words_s;
    t0 = ticks_s;
    b0 = cmds_s;
    pat_s = 12'($urandom());
    push_s();
    push_s();
    step(); fs_s = 1'b1;
    wait_cnt(4, b0 + 2, 80, "s_b2b_second_cmd");
    chk("s_b2b_gap", cmd_cyc_s - tick_cyc_s, 2);
    step(); fs_s = 1'b0;
    wait_cnt(2, t0 + 2, 80, "s_b2b_ticks");
    repeat (10) @(negedge clk);
    chk("s_b2b_total_ticks", ticks_s - t0, 2);
    chk("s_b2b_words", words_s - w0, 2 * (SN + 1));
    chk("s_queue_drained", exp_s.size(), 0);
    chk("s_idle_end", busy_s, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
